// File: rtl/sw_addr_ctrl.sv
// Switch-driven debug read controller: debounces board switches, encodes the highest
// set switch into a read address, issues rd_req/rd_ack reads and holds the result for display.
module sw_addr_ctrl #(
  parameter int unsigned DEB_CYCLES     = 50000,
  parameter int unsigned ACK_TIMEOUT    = 255,
  parameter int unsigned REFRESH_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw,
  output logic        rd_req,
  output logic [3:0]  rd_addr,
  input  logic        rd_ack,
  input  logic [31:0] rd_data,
  output logic [31:0] disp_data,
  output logic [3:0]  disp_addr,
  output logic        disp_valid,
  output logic        timeout_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [31:0] DEB_LAST = (DEB_CYCLES == 0)     ? 32'd0 : 32'(DEB_CYCLES - 1);
  localparam logic [31:0] ACK_LAST = (ACK_TIMEOUT == 0)    ? 32'd0 : 32'(ACK_TIMEOUT - 1);
  localparam logic [31:0] REF_LAST = (REFRESH_CYCLES == 0) ? 32'd0 : 32'(REFRESH_CYCLES - 1);
  localparam bit          REF_EN   = (REFRESH_CYCLES != 0);

  logic [15:0] sw_meta_reg, sw_sync_reg, sw_stable_reg;
  logic [31:0] deb_cnt_reg, ref_cnt_reg, to_cnt_reg;
  logic        stable_upd_reg, pending_reg, rd_req_reg, busy_reg;
  logic        disp_valid_reg, timeout_err_reg;
  logic [3:0]  rd_addr_reg, disp_addr_reg, last_idx_reg, enc_idx;
  logic [31:0] disp_data_reg;
  state_t      state_reg;
  logic        change_evt, refresh_tick;

  function automatic logic [3:0] enc_hi(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++)
      if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  assign enc_idx      = enc_hi(sw_stable_reg);
  assign change_evt   = stable_upd_reg && (enc_idx != last_idx_reg);
  assign refresh_tick = REF_EN && (state_reg == IDLE) && (ref_cnt_reg == REF_LAST);

  // Synchronizer and debounce; the counter restarts on the edge where sw_sync is about to change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_reg    <= '0;
      sw_sync_reg    <= '0;
      sw_stable_reg  <= '0;
      deb_cnt_reg    <= '0;
      stable_upd_reg <= 1'b0;
    end else begin
      sw_meta_reg    <= sw;
      sw_sync_reg    <= sw_meta_reg;
      stable_upd_reg <= 1'b0;
      if ((sw_meta_reg != sw_sync_reg) || (sw_sync_reg == sw_stable_reg)) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg == DEB_LAST) begin
        sw_stable_reg  <= sw_sync_reg;
        stable_upd_reg <= 1'b1;
        deb_cnt_reg    <= '0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      pending_reg     <= 1'b1;
      rd_req_reg      <= 1'b0;
      rd_addr_reg     <= '0;
      last_idx_reg    <= '0;
      disp_data_reg   <= '0;
      disp_addr_reg   <= '0;
      disp_valid_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;
      busy_reg        <= 1'b0;
      ref_cnt_reg     <= '0;
      to_cnt_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pending_reg) begin
            rd_addr_reg  <= enc_idx;
            last_idx_reg <= enc_idx;
            rd_req_reg   <= 1'b1;
            to_cnt_reg   <= '0;
            ref_cnt_reg  <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= REQ;
          end else if (REF_EN) begin
            ref_cnt_reg <= refresh_tick ? 32'd0 : ref_cnt_reg + 32'd1;
          end
        end
        REQ: begin
          if (rd_ack) begin
            disp_data_reg   <= rd_data;
            disp_addr_reg   <= rd_addr_reg;
            disp_valid_reg  <= 1'b1;
            timeout_err_reg <= 1'b0;
            rd_req_reg      <= 1'b0;
            state_reg       <= DONE;
          end else if (to_cnt_reg == ACK_LAST) begin
            disp_valid_reg  <= 1'b0;
            timeout_err_reg <= 1'b1;
            rd_req_reg      <= 1'b0;
            state_reg       <= DONE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 32'd1;
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          rd_req_reg <= 1'b0;
          busy_reg   <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
      // New events win over the clear so a change seen during issue is not lost.
      if (change_evt || refresh_tick)
        pending_reg <= 1'b1;
      else if ((state_reg == IDLE) && pending_reg)
        pending_reg <= 1'b0;
    end
  end

  assign rd_req      = rd_req_reg;
  assign rd_addr     = rd_addr_reg;
  assign disp_data   = disp_data_reg;
  assign disp_addr   = disp_addr_reg;
  assign disp_valid  = disp_valid_reg;
  assign timeout_err = timeout_err_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_sw_addr_ctrl.sv
// Directed bench for sw_addr_ctrl: vector table for address encoding/latency plus
// hand-written sequences for debounce, timeout, collapsing and mid-request reset.
module tb_sw_addr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw;
  logic        rd_req, rd_ack, disp_valid, timeout_err, busy;
  logic [3:0]  rd_addr, disp_addr;
  logic [31:0] rd_data, disp_data;

  int total = 0;
  int bad   = 0;

  // slave model controls and request monitor
  int          ack_delay  = 3;
  bit          ack_en     = 1'b1;
  bit          stray_ack  = 1'b0;
  logic [31:0] slave_data = 32'h0;
  logic [3:0]  req_log[$];
  int          high_cnt   = 0;
  int          ack_cnt    = 0;
  bit          addr_moved = 1'b0;
  bit          req_prev   = 1'b0;
  logic [3:0]  cur_addr   = 4'd0;

  typedef struct {
    logic [15:0] sw;
    logic [31:0] data;
    bit          exp_req;
    logic [3:0]  exp_addr;
    logic [31:0] exp_disp;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  sw_addr_ctrl #(.DEB_CYCLES(4), .ACK_TIMEOUT(10), .REFRESH_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .sw(sw),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .disp_data(disp_data), .disp_addr(disp_addr), .disp_valid(disp_valid),
    .timeout_err(timeout_err), .busy(busy)
  );

  initial begin
    rd_ack  = 1'b0;
    rd_data = 32'h0;
    forever begin
      @(negedge clk);
      if (rd_req) begin
        if (!req_prev) begin
          req_log.push_back(rd_addr);
          cur_addr = rd_addr;
          high_cnt = 0;
          ack_cnt  = 0;
        end else if (rd_addr != cur_addr) begin
          addr_moved = 1'b1;
        end
        high_cnt++;
        ack_cnt++;
        if (ack_en && ack_cnt == ack_delay) begin
          rd_ack  = 1'b1;
          rd_data = slave_data;
        end else begin
          rd_ack  = 1'b0;
          rd_data = 32'hBAD0BAD0;
        end
      end else begin
        rd_ack  = stray_ack;
        rd_data = stray_ack ? 32'h5A5A5A5A : 32'h0;
      end
      req_prev = rd_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic wait_rise(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (rd_req) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string nm, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!busy && !rd_req) break;
      tick();
    end
    chk({nm, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int fall;
    vecs[0] = '{16'h0120, 32'h11111111, 1'b1, 4'd8,  32'h11111111};
    vecs[1] = '{16'h0128, 32'h99999999, 1'b0, 4'd8,  32'h11111111};
    vecs[2] = '{16'h8000, 32'h22222222, 1'b1, 4'd15, 32'h22222222};
    vecs[3] = '{16'h0001, 32'h33333333, 1'b1, 4'd0,  32'h33333333};
    vecs[4] = '{16'h0003, 32'h44444444, 1'b1, 4'd1,  32'h44444444};
    vecs[5] = '{16'h7FFF, 32'h55555555, 1'b1, 4'd14, 32'h55555555};
    vecs[6] = '{16'h0010, 32'h66666666, 1'b1, 4'd4,  32'h66666666};
    vecs[7] = '{16'h0001, 32'h77777777, 1'b1, 4'd0,  32'h77777777};

    // reset state, then the initial address-0 read
    rst = 1'b1;
    sw  = 16'h0000;
    slave_data = 32'hDEADBEEF;
    repeat (3) tick();
    chk("rst rd_req", {31'd0, rd_req}, 32'd0);
    chk("rst rd_addr", {28'd0, rd_addr}, 32'd0);
    chk("rst disp_data", disp_data, 32'd0);
    chk("rst disp_valid", {31'd0, disp_valid}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    wait_rise(5, n);
    chk("init latency", n, 32'd1);
    chk("init rd_addr", {28'd0, rd_addr}, 32'd0);
    wait_idle("init", 20);
    chk("init nreq", req_log.size(), 32'd1);
    chk("init disp_data", disp_data, 32'hDEADBEEF);
    chk("init disp_addr", {28'd0, disp_addr}, 32'd0);
    chk("init disp_valid", {31'd0, disp_valid}, 32'd1);
    chk("init busy", {31'd0, busy}, 32'd0);

    // table: 2 sync + 4 debounce + 2 issue cycles from switch change to rd_req
    for (int v = 0; v < 8; v++) begin
      slave_data = vecs[v].data;
      req_log.delete();
      sw = vecs[v].sw;
      wait_rise(20, n);
      if (vecs[v].exp_req) begin
        chk($sformatf("v%0d latency", v), n, 32'd8);
        wait_idle($sformatf("v%0d", v), 30);
        chk($sformatf("v%0d nreq", v), req_log.size(), 32'd1);
        chk($sformatf("v%0d rd_addr", v),
            {28'd0, (req_log.size() > 0) ? req_log[0] : 4'hX}, {28'd0, vecs[v].exp_addr});
      end else begin
        chk($sformatf("v%0d nreq", v), req_log.size(), 32'd0);
      end
      chk($sformatf("v%0d disp_addr", v), {28'd0, disp_addr}, {28'd0, vecs[v].exp_addr});
      chk($sformatf("v%0d disp_data", v), disp_data, vecs[v].exp_disp);
      chk($sformatf("v%0d disp_valid", v), {31'd0, disp_valid}, 32'd1);
    end
    chk("rd_addr held", {31'd0, addr_moved}, 32'd0);

    // bounce on bit 3 with stray acks while idle: nothing may be issued or captured
    req_log.delete();
    stray_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sw = (i % 2 == 0) ? 16'h0009 : 16'h0001;
      tick();
      tick();
    end
    sw = 16'h0001;
    repeat (20) tick();
    stray_ack = 1'b0;
    tick();
    chk("bounce nreq", req_log.size(), 32'd0);
    chk("bounce disp_data", disp_data, 32'h77777777);
    chk("bounce disp_addr", {28'd0, disp_addr}, 32'd0);

    // slave never acks: 10 cycles of rd_req, then one DONE cycle
    ack_en = 1'b0;
    req_log.delete();
    sw = 16'h0100;
    wait_rise(20, n);
    chk("tmo latency", n, 32'd8);
    fall = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!rd_req) begin
        fall = 1;
        break;
      end
    end
    chk("tmo fell", fall, 32'd1);
    chk("tmo high cycles", high_cnt, 32'd10);
    chk("tmo timeout_err", {31'd0, timeout_err}, 32'd1);
    chk("tmo disp_valid", {31'd0, disp_valid}, 32'd0);
    chk("tmo disp_data", disp_data, 32'h77777777);
    chk("tmo done busy", {31'd0, busy}, 32'd1);
    tick();
    chk("tmo idle busy", {31'd0, busy}, 32'd0);
    ack_en = 1'b1;

    // changes during REQ collapse into one follow-up at the index current at issue
    slave_data = 32'hA1A1A1A1;
    sw = 16'h0001;
    wait_rise(20, n);
    wait_idle("pre", 30);
    req_log.delete();
    ack_delay  = 9;
    slave_data = 32'hB2B2B2B2;
    sw = 16'h8000;
    wait_rise(20, n);
    chk("coll first addr", {28'd0, rd_addr}, 32'd15);
    sw = 16'h0010;
    repeat (40) tick();
    ack_delay = 3;
    chk("coll nreq", req_log.size(), 32'd2);
    chk("coll second addr", {28'd0, (req_log.size() > 1) ? req_log[1] : 4'hX}, 32'd4);
    chk("coll disp_addr", {28'd0, disp_addr}, 32'd4);
    chk("coll disp_valid", {31'd0, disp_valid}, 32'd1);
    chk("coll timeout_err", {31'd0, timeout_err}, 32'd0);

    // reset in the middle of a request
    ack_en = 1'b0;
    sw = 16'h0200;
    wait_rise(20, n);
    tick();
    chk("mid rd_req before", {31'd0, rd_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid rst rd_req", {31'd0, rd_req}, 32'd0);
    chk("mid rst rd_addr", {28'd0, rd_addr}, 32'd0);
    chk("mid rst disp_data", disp_data, 32'd0);
    chk("mid rst disp_addr", {28'd0, disp_addr}, 32'd0);
    chk("mid rst disp_valid", {31'd0, disp_valid}, 32'd0);
    chk("mid rst timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("mid rst busy", {31'd0, busy}, 32'd0);
    sw = 16'h0000;
    ack_en = 1'b1;
    slave_data = 32'hCAFEF00D;
    repeat (3) tick();
    rst = 1'b0;
    req_log.delete();
    wait_rise(5, n);
    chk("post rst latency", n, 32'd1);
    chk("post rst rd_addr", {28'd0, rd_addr}, 32'd0);
    wait_idle("post rst", 20);
    chk("post rst disp_data", disp_data, 32'hCAFEF00D);
    chk("post rst disp_valid", {31'd0, disp_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sw_addr_ctrl.md
SW_ADDR_CTRL -- requirements
Module: sw_addr_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 50000: consecutive stable cycles required to accept a switch change.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255: maximum cycles rd_req waits for rd_ack.
REQ-003 SHALL have parameter REFRESH_CYCLES, default 1000000: idle cycles between automatic re-reads; 0 disables refresh.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port sw, input, 16: raw board switches, asynchronous to clk.
REQ-007 SHALL have port rd_req, output, 1: debug read request to register/memory port.
REQ-008 SHALL have port rd_addr, output, 4: read address, valid while rd_req=1.
REQ-009 SHALL have port rd_ack, input, 1: read acknowledge; rd_data is valid in the same cycle.
REQ-010 SHALL have port rd_data, input, 32: returned read data.
REQ-011 SHALL have port disp_data, output, 32: last successfully read word.
REQ-012 SHALL have port disp_addr, output, 4: address of disp_data.
REQ-013 SHALL have port disp_valid, output, 1: disp_data/disp_addr hold a completed read.
REQ-014 SHALL have port timeout_err, output, 1: last request timed out.
REQ-015 SHALL have port busy, output, 1: FSM not in IDLE.

Function
REQ-016 SHALL pass sw through a 2-flop synchronizer to sw_sync before any other use.
REQ-017 SHALL run a debounce counter that restarts at 0 whenever sw_sync changes value, and SHALL copy sw_sync into sw_stable once sw_sync has differed from sw_stable and held the same value for DEB_CYCLES consecutive cycles.
REQ-018 SHALL encode sw_stable to the index of its highest set bit; all-zero SHALL encode to 0.
REQ-019 SHALL set a pending flag in the cycle sw_stable updates and its encoded index differs from the index of the last issued request.
REQ-020 SHALL also set pending when the refresh counter, which counts only in IDLE and clears on every request, reaches REFRESH_CYCLES (when nonzero).
REQ-021 SHALL implement FSM states IDLE, REQ, DONE.
REQ-022 IDLE: when pending=1, SHALL latch rd_addr from the current encoded index, clear pending, and enter REQ on the next cycle.
REQ-023 REQ: SHALL hold rd_req=1 and rd_addr constant until rd_ack=1 or timeout.
REQ-024 REQ with rd_ack=1: SHALL capture disp_data<=rd_data and disp_addr<=rd_addr, set disp_valid=1, clear timeout_err, and enter DONE.
REQ-025 REQ for ACK_TIMEOUT cycles without rd_ack: SHALL set timeout_err=1, clear disp_valid, leave disp_data unchanged, and enter DONE.
REQ-026 DONE: SHALL drive rd_req=0 for exactly one cycle, then enter IDLE, guaranteeing at least one low cycle between requests.
REQ-027 SHALL ignore rd_ack in IDLE and DONE.
REQ-028 A switch change or refresh tick occurring in REQ or DONE SHALL set pending; the next request SHALL use the encoded index at issue time, and multiple changes SHALL collapse into one request.
REQ-029 Latency: rd_req SHALL rise 2 cycles after the sw_stable update when the FSM is IDLE.
REQ-030 busy SHALL be 1 exactly when the state is REQ or DONE.

Reset
REQ-031 rst=1 SHALL asynchronously force the state to IDLE and set rd_req=0, rd_addr=0, disp_data=0, disp_addr=0, disp_valid=0, timeout_err=0, sw_sync=0, sw_stable=0, and all counters to 0.
REQ-032 Pending SHALL reset to 1, so an initial read of address 0 is issued after reset release.
REQ-033 Reset asserted mid-request SHALL abort the request with rd_req low immediately and discard any response.

Verification
REQ-034 Release reset with sw=0 and the slave acking after 3 cycles with 0xDEADBEEF -> one rd_req at addr 0; disp_data=0xDEADBEEF, disp_addr=0, disp_valid=1.
REQ-035 Set sw=0x0120 (DEB_CYCLES=4) and hold -> rd_req with rd_addr=8 after synchronizer + 4 stable cycles + 2 cycles; rd_addr stays 8 until ack.
REQ-036 Toggle sw bit 3 every 2 cycles for 20 cycles with DEB_CYCLES=4 -> no rd_req issued and sw_stable unchanged.
REQ-037 Slave never acks with ACK_TIMEOUT=10 -> rd_req high for exactly 10 cycles, then timeout_err=1, disp_valid=0, one DONE cycle, return to IDLE.
REQ-038 Change sw from 0x0001 to 0x8000 and then to 0x0010 while the first request is in REQ -> exactly one follow-up request, with rd_addr=4.
REQ-039 Assert rst while rd_req=1 -> rd_req=0 in the same cycle, all outputs 0, and a fresh addr-0 read after release.
